// File: rtl/riscv_pkg.sv
// Shared RV32 register-file constants and the writeback source select type.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    SelNone,
    SelPri,
    SelSec
  } wb_sel_e;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] r);
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered secondary writebacks; push when full and pop
// when empty are ignored.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: only count/pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges primary pipeline writeback and FIFO-buffered long-latency results onto
// the register file's single write port, and tracks pending destinations.
module wb_write_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = riscv_pkg::XLEN,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pri_valid,
  input  logic [REG_ADDR_W-1:0] pri_rd,
  input  logic [XLEN-1:0]       pri_data,
  input  logic                  sec_valid,
  output logic                  sec_ready,
  input  logic [REG_ADDR_W-1:0] sec_rd,
  input  logic [XLEN-1:0]       sec_data,
  input  logic                  sb_set,
  input  logic [REG_ADDR_W-1:0] sb_set_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  stall_req,
  output logic [CNT_W-1:0]      fifo_count
);

  localparam int unsigned ENTRY_W  = REG_ADDR_W + XLEN;
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    head_entry;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  pri_win;
  wb_sel_e               sel;
  logic [NUM_REGS-1:0]   sb_q, sb_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({sec_rd, sec_data}),
    .pop   (fifo_pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_rd, head_data} = head_entry;
  assign sec_ready = !fifo_full;

  // x0 results are acknowledged but dropped so they never occupy a slot.
  assign fifo_push = sec_valid && !fifo_full && !is_x0(sec_rd);
  assign pri_win   = pri_valid && !is_x0(pri_rd);

  always_comb begin
    sel = SelNone;
    if (pri_win) begin
      sel = SelPri;
    end else if (!fifo_empty) begin
      sel = SelSec;
    end
  end

  assign fifo_pop = (sel == SelSec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= REG_ZERO;
      rf_wdata <= '0;
    end else begin
      case (sel)
        SelPri: begin
          rf_we    <= 1'b1;
          rf_waddr <= pri_rd;
          rf_wdata <= pri_data;
        end
        SelSec: begin
          rf_we    <= 1'b1;
          rf_waddr <= head_rd;
          rf_wdata <= head_data;
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

  // Clear is applied first so a same-register set in the same cycle wins.
  always_comb begin
    sb_d = sb_q;
    if (fifo_pop) begin
      sb_d[head_rd] = 1'b0;
    end
    if (sb_set && !is_x0(sb_set_rd)) begin
      sb_d[sb_set_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign busy1 = sb_q[rs1];
  assign busy2 = sb_q[rs2];

  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q  <= '0;
      stall_req <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      stall_req <= (starve_d == STARVE_W'(STARVE_MAX));
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based model of the arbiter.
module tb_wb_write_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned STARVE_MAX = 8;
  localparam int unsigned CW         = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pri_valid, sec_valid, sec_ready, sb_set;
  logic [4:0]      pri_rd, sec_rd, sb_set_rd, rs1, rs2, rf_waddr;
  logic [XLEN-1:0] pri_data, sec_data, rf_wdata;
  logic            busy1, busy2, rf_we, stall_req;
  logic [CW-1:0]   fifo_count;

  int tests = 0;
  int fails = 0;

  wb_write_arbiter #(
    .XLEN       (XLEN),
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pri_valid  (pri_valid),
    .pri_rd     (pri_rd),
    .pri_data   (pri_data),
    .sec_valid  (sec_valid),
    .sec_ready  (sec_ready),
    .sec_rd     (sec_rd),
    .sec_data   (sec_data),
    .sb_set     (sb_set),
    .sb_set_rd  (sb_set_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .busy1      (busy1),
    .busy2      (busy2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_req  (stall_req),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit [31:0]   m_sb     = '0;
  int unsigned m_starve = 0;
  bit          m_stall  = 1'b0;
  bit          m_we     = 1'b0;
  logic [4:0]  m_waddr  = '0;
  logic [31:0] m_wdata  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending results and a pending-register set.
  initial begin : model
    bit          pri, pop, push;
    int unsigned n;
    ent_t        head;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_sb = '0; m_starve = 0; m_stall = 0;
        m_we = 0; m_waddr = '0; m_wdata = '0;
      end else begin
        n    = mq.size();
        pri  = pri_valid && (pri_rd != 0);
        pop  = !pri && (n > 0);
        push = sec_valid && (n < DEPTH) && (sec_rd != 0);
        if (n > 0) head = mq[0];
        if (pri) begin
          m_we = 1; m_waddr = pri_rd; m_wdata = pri_data;
        end else if (pop) begin
          m_we = 1; m_waddr = head.rd; m_wdata = head.data;
        end else begin
          m_we = 0;
        end
        if (pop) begin
          m_sb[head.rd] = 1'b0;
          mq.delete(0);
        end
        if (push) mq.push_back('{rd: sec_rd, data: sec_data});
        if (pop || n == 0) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
        m_stall = (m_starve == STARVE_MAX);
        if (sb_set && sb_set_rd != 0) m_sb[sb_set_rd] = 1'b1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("m_rf_we",     rf_we,      m_we);
      chk("m_rf_waddr",  rf_waddr,   m_waddr);
      chk("m_rf_wdata",  rf_wdata,   m_wdata);
      chk("m_count",     fifo_count, mq.size());
      chk("m_sec_ready", sec_ready,  mq.size() < DEPTH);
      chk("m_stall_req", stall_req,  m_stall);
      chk("m_busy1",     busy1,      m_sb[rs1]);
      chk("m_busy2",     busy2,      m_sb[rs2]);
    end
  end

  task automatic idle();
    pri_valid = 0; pri_rd = 0; pri_data = 0;
    sec_valid = 0; sec_rd = 0; sec_data = 0;
    sb_set = 0; sb_set_rd = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    idle();
    rs1 = 0; rs2 = 0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_sec_ready", sec_ready, 1);
    step();
    rst = 1;

    // Primary only
    pri_valid = 1; pri_rd = 5; pri_data = 32'hDEADBEEF;
    step();
    chk("pri_we", rf_we, 1);
    chk("pri_waddr", rf_waddr, 5);
    chk("pri_wdata", rf_wdata, 32'hDEADBEEF);
    idle();
    step();
    chk("pri_we_off", rf_we, 0);
    chk("pri_waddr_hold", rf_waddr, 5);

    // Collision: primary wins, secondary follows next cycle
    sb_set = 1; sb_set_rd = 7; rs1 = 7;
    step();
    idle();
    pri_valid = 1; pri_rd = 3; pri_data = 32'h11;
    sec_valid = 1; sec_rd = 7; sec_data = 32'h22;
    step();
    chk("col_waddr1", rf_waddr, 3);
    chk("col_wdata1", rf_wdata, 32'h11);
    chk("col_count1", fifo_count, 1);
    chk("col_busy_set", busy1, 1);
    idle();
    step();
    chk("col_we2", rf_we, 1);
    chk("col_waddr2", rf_waddr, 7);
    chk("col_wdata2", rf_wdata, 32'h22);
    chk("col_busy_clr", busy1, 0);

    // Backpressure and starvation
    pri_valid = 1; pri_rd = 1;
    for (int i = 0; i < 4; i++) begin
      pri_data = i; sec_valid = 1; sec_rd = 5'(10 + i); sec_data = 32'(100 + i);
      step();
    end
    chk("bp_ready", sec_ready, 0);
    chk("bp_count", fifo_count, 4);
    sec_rd = 15; sec_data = 32'hBAD;
    repeat (4) step();
    chk("bp_stall_lo", stall_req, 0);
    step();
    chk("bp_stall_hi", stall_req, 1);
    step();
    chk("bp_stall_sat", stall_req, 1);
    chk("bp_full_reject", fifo_count, 4);
    pri_valid = 0;
    step();
    chk("bp_pop_waddr", rf_waddr, 10);
    chk("bp_pop_wdata", rf_wdata, 100);
    chk("bp_stall_drop", stall_req, 0);
    chk("bp_count_pop", fifo_count, 3);
    sec_valid = 0;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("bp_drain_order", rf_waddr, 10 + i);
    end
    step();
    chk("bp_empty", fifo_count, 0);

    // x0 handling
    idle();
    sec_valid = 1; sec_rd = 14; sec_data = 32'hE;
    step();
    chk("x0_queued", fifo_count, 1);
    idle();
    pri_valid = 1; pri_rd = 0; pri_data = 32'h55;
    step();
    chk("x0_pri_waddr", rf_waddr, 14);
    chk("x0_pri_wdata", rf_wdata, 32'hE);
    idle();
    sec_valid = 1; sec_rd = 0; sec_data = 32'h77;
    step();
    chk("x0_sec_count", fifo_count, 0);
    chk("x0_sec_we", rf_we, 0);
    idle();
    sb_set = 1; sb_set_rd = 0; rs1 = 0;
    step();
    chk("x0_busy", busy1, 0);

    // Scoreboard set-wins
    idle();
    sb_set = 1; sb_set_rd = 9;
    step();
    idle();
    rs1 = 9; #1;
    chk("sb_busy_comb", busy1, 1);
    rs1 = 8; #1;
    chk("sb_busy_comb_other", busy1, 0);
    rs1 = 9;
    pri_valid = 1; pri_rd = 2; sec_valid = 1; sec_rd = 9; sec_data = 32'h99;
    step();
    idle();
    sb_set = 1; sb_set_rd = 9;
    step();
    chk("sb_pop_waddr", rf_waddr, 9);
    chk("sb_set_wins", busy1, 1);
    idle();
    step();
    chk("sb_still_busy", busy1, 1);

    // Asynchronous reset with entries queued
    pri_valid = 1; pri_rd = 2; rs2 = 5;
    for (int i = 0; i < 3; i++) begin
      sec_valid = 1; sec_rd = 5'(4 + i); sec_data = 32'(i);
      sb_set = 1; sb_set_rd = 5'(4 + i);
      step();
    end
    chk("ar_count_pre", fifo_count, 3);
    #2 rst = 0;
    #1;
    chk("ar_rf_we", rf_we, 0);
    chk("ar_count", fifo_count, 0);
    chk("ar_sec_ready", sec_ready, 1);
    chk("ar_busy1", busy1, 0);
    chk("ar_busy2", busy2, 0);
    chk("ar_stall", stall_req, 0);
    idle();
    step();
    rst = 1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 399) != 0);
      pri_valid = ($urandom_range(0, 9) < 4);
      pri_rd    = 5'($urandom_range(0, 15));
      pri_data  = $urandom;
      sec_valid = ($urandom_range(0, 9) < 6);
      sec_rd    = 5'($urandom_range(0, 15));
      sec_data  = $urandom;
      sb_set    = ($urandom_range(0, 9) < 3);
      sb_set_rd = 5'($urandom_range(0, 15));
      rs1       = 5'($urandom_range(0, 15));
      rs2       = 5'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
